step_ctrl: RTL and testbench
============================

STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the executed-step counter.
REQ-002 clk_in  input  1  system clock; all state updates on the rising edge.
REQ-003 RST_in  input  1  reset, asynchronous, active-high.
REQ-004 step_pulse_in  input  1  one-cycle pulse from a debounce stage; step/run/pause request.
REQ-005 mode_pulse_in  input  1  one-cycle pulse from a second debounce stage; mode select.
REQ-006 halt_in  input  1  level from the CPU; high means the CPU has executed a halt.
REQ-007 burst_len_in  input  4  burst length in cycles; 0 means 16.
REQ-008 cpu_en_out  output  1  registered CPU clock-enable.
REQ-009 mode_out  output  2  current mode: 0 SINGLE, 1 BURST, 2 RUN.
REQ-010 busy_out  output  1  high whenever the state is not PAUSED.
REQ-011 step_cnt_out  output  CNT_W  count of cycles with cpu_en_out high.

Function
REQ-012 States SHALL be PAUSED, STEP, BURST, RUN and HALTED.
REQ-013 In PAUSED, mode_pulse_in SHALL advance mode_out 0->1->2->0; mode encoding 3 is never produced.
REQ-014 mode_pulse_in outside PAUSED SHALL be ignored.
REQ-015 PAUSED with step_pulse_in and mode 0 SHALL go to STEP.
  - cpu_en_out high exactly one cycle, then return to PAUSED.
REQ-016 PAUSED with step_pulse_in and mode 1 SHALL go to BURST.
  - burst_len_in captured into a down-counter on the same edge.
  - cpu_en_out high for exactly that many consecutive cycles (16 if captured value is 0), then return to PAUSED.
REQ-017 PAUSED with step_pulse_in and mode 2 SHALL go to RUN.
  - cpu_en_out held high until step_pulse_in, then return to PAUSED.
REQ-018 Latency: a pulse sampled at edge N SHALL give cpu_en_out high from the cycle following edge N (one register stage); exit from RUN drops cpu_en_out from the cycle after the pulse edge.
REQ-019 step_pulse_in during STEP or BURST SHALL be ignored, not queued.
REQ-020 Simultaneous step_pulse_in and mode_pulse_in in PAUSED: the mode change SHALL take effect and the step SHALL be dropped.
REQ-021 halt_in high in STEP, BURST or RUN SHALL force HALTED on that edge.
  - cpu_en_out low from the next cycle.
  - halt_in has priority over step_pulse_in and burst completion.
REQ-022 In HALTED, cpu_en_out SHALL stay low.
  - step_pulse_in with halt_in low returns to PAUSED.
  - step_pulse_in with halt_in still high is ignored.
REQ-023 halt_in in PAUSED SHALL be ignored.
  - A step request while halt_in is high produces at most the first enable cycle before HALTED is entered.
REQ-024 step_cnt_out SHALL increment by one on every edge where cpu_en_out is high, wrapping modulo 2^CNT_W.
REQ-025 burst_len_in changes during BURST SHALL NOT affect the burst in progress.

Reset
REQ-026 While RST_in is high, all outputs and state SHALL reset immediately (asynchronously):
  - state PAUSED
  - mode_out 0
  - cpu_en_out 0
  - busy_out 0
  - step_cnt_out 0
  - burst counter 0
REQ-027 Reset asserted mid-BURST or mid-RUN SHALL abort the operation with no further enable cycles after release.
REQ-028 Pulses coincident with the first edge after reset release SHALL be processed normally.

Structure
REQ-029 State encodings, mode encodings and the burst-length-0 substitute value (16) SHALL reside in the shared lab package.
REQ-030 The block SHALL be a single module with no sub-modules; the debounce stages are instantiated by the parent.

Verification
REQ-031 Single step: mode 0, one step pulse -> cpu_en_out high exactly 1 cycle, step_cnt_out 0->1, busy_out high 1 cycle.
REQ-032 Burst: mode 1, burst_len_in=5, step pulse, second step pulse mid-burst -> exactly 5 enable cycles, step_cnt_out=5; repeat with burst_len_in=0 -> 16 cycles.
REQ-033 Run then pause: mode 2, step pulse, wait 100 cycles, step pulse -> 100 or 101 enable cycles per REQ-018, then PAUSED, cpu_en_out 0.
REQ-034 Halt: RUN, raise halt_in -> HALTED, cpu_en_out 0 next cycle; step pulse with halt_in high stays HALTED; drop halt_in, step pulse -> PAUSED.
REQ-035 Simultaneous pulses in PAUSED mode 0 -> mode_out=1, no enable cycle; mode pulse during RUN -> mode_out unchanged.
REQ-036 Reset mid-BURST (len 10, after 3 cycles) -> all outputs zero immediately, no enables after release; step_cnt_out wrap check with CNT_W=4: 17 steps -> 1.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the step controller: FSM states, mode values and
// the burst length used when the requested length is zero.
package step_ctrl_pkg;

  localparam logic [2:0] ST_PAUSED = 3'd0;
  localparam logic [2:0] ST_STEP   = 3'd1;
  localparam logic [2:0] ST_BURST  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_BURST  = 2'd1;
  localparam logic [1:0] MODE_RUN    = 2'd2;

  // A requested burst length of zero stands for the longest burst.
  localparam logic [4:0] BURST_ZERO_LEN = 5'd16;

  // Mode rotation SINGLE -> BURST -> RUN -> SINGLE; encoding 3 folds to SINGLE.
  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      MODE_SINGLE: nxt = MODE_BURST;
      MODE_BURST:  nxt = MODE_RUN;
      MODE_RUN:    nxt = MODE_SINGLE;
      default:     nxt = MODE_SINGLE;
    endcase
    return nxt;
  endfunction

  // Number of enable cycles for a burst request of the given length.
  function automatic logic [4:0] burst_load(input logic [3:0] len);
    logic [4:0] cnt;
    if (len == 4'd0) begin
      cnt = BURST_ZERO_LEN;
    end else begin
      cnt = {1'b0, len};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/step_ctrl.sv
// CPU single-step / burst / run controller. Turns debounced button pulses
// into a registered CPU clock-enable and counts the enabled cycles.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             RST_in,
  input  logic             step_pulse_in,
  input  logic             mode_pulse_in,
  input  logic             halt_in,
  input  logic [3:0]       burst_len_in,
  output logic             cpu_en_out,
  output logic [1:0]       mode_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] step_cnt_out
);

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [1:0]       mode_r;
  logic [1:0]       mode_nxt_s;
  logic [4:0]       burst_cnt_r;
  logic [4:0]       burst_nxt_s;
  logic             cpu_en_r;
  logic             cpu_en_nxt_s;
  logic             busy_r;
  logic [CNT_W-1:0] step_cnt_r;

  // Next-state, mode and burst-counter decode; halt wins over every other event.
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    burst_nxt_s = burst_cnt_r;
    case (state_r)
      ST_PAUSED: begin
        if (mode_pulse_in) begin
          // A coincident step pulse is deliberately dropped here.
          mode_nxt_s = next_mode(mode_r);
        end else if (step_pulse_in) begin
          case (mode_r)
            MODE_SINGLE: state_nxt_s = ST_STEP;
            MODE_BURST: begin
              state_nxt_s = ST_BURST;
              burst_nxt_s = burst_load(burst_len_in);
            end
            MODE_RUN:    state_nxt_s = ST_RUN;
            default:     state_nxt_s = ST_PAUSED;
          endcase
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      ST_STEP: begin
        if (halt_in) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_PAUSED;
        end
      end
      ST_BURST: begin
        if (halt_in) begin
          state_nxt_s = ST_HALTED;
          burst_nxt_s = 5'd0;
        end else if (burst_cnt_r <= 5'd1) begin
          state_nxt_s = ST_PAUSED;
          burst_nxt_s = 5'd0;
        end else begin
          burst_nxt_s = burst_cnt_r - 5'd1;
        end
      end
      ST_RUN: begin
        if (halt_in) begin
          state_nxt_s = ST_HALTED;
        end else if (step_pulse_in) begin
          state_nxt_s = ST_PAUSED;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (step_pulse_in && !halt_in) begin
          state_nxt_s = ST_PAUSED;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      default: begin
        state_nxt_s = ST_PAUSED;
        burst_nxt_s = 5'd0;
      end
    endcase
  end

  // The CPU runs in any cycle whose state is one of the executing states.
  always_comb begin
    if ((state_nxt_s == ST_STEP) || (state_nxt_s == ST_BURST) ||
        (state_nxt_s == ST_RUN)) begin
      cpu_en_nxt_s = 1'b1;
    end else begin
      cpu_en_nxt_s = 1'b0;
    end
  end

  // FSM, mode and registered status outputs.
  always_ff @(posedge clk_in or posedge RST_in) begin
    if (RST_in) begin
      state_r     <= ST_PAUSED;
      mode_r      <= MODE_SINGLE;
      burst_cnt_r <= 5'd0;
      cpu_en_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mode_r      <= mode_nxt_s;
      burst_cnt_r <= burst_nxt_s;
      cpu_en_r    <= cpu_en_nxt_s;
      busy_r      <= (state_nxt_s != ST_PAUSED);
    end
  end

  // Executed-step counter: one count per edge with the enable high, wrapping.
  always_ff @(posedge clk_in or posedge RST_in) begin
    if (RST_in) begin
      step_cnt_r <= '0;
    end else if (cpu_en_r) begin
      step_cnt_r <= step_cnt_r + CNT_W'(1);
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  assign cpu_en_out   = cpu_en_r;
  assign mode_out     = mode_r;
  assign busy_out     = busy_r;
  assign step_cnt_out = step_cnt_r;

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: directed scenarios plus randomized
// pulses, compared every cycle against a behavioural model. A second
// instance with a 4-bit counter shares the stimulus to exercise wrapping.
module tb_step_ctrl;

  logic       clk_in = 1'b0;
  logic       RST_in;
  logic       step_pulse_in;
  logic       mode_pulse_in;
  logic       halt_in;
  logic [3:0] burst_len_in;

  logic        cpu_en_out;
  logic [1:0]  mode_out;
  logic        busy_out;
  logic [15:0] step_cnt_out;

  logic        cpu_en4;
  logic [1:0]  mode4;
  logic        busy4;
  logic [3:0]  step_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: enables still owed (-1 means unlimited), halt flag.
  int m_mode;
  int m_left;
  int m_cnt;
  bit m_halted;
  bit m_en;

  always #5 clk_in = ~clk_in;

  step_ctrl #(.CNT_W(16)) dut (
    .clk_in        (clk_in),
    .RST_in        (RST_in),
    .step_pulse_in (step_pulse_in),
    .mode_pulse_in (mode_pulse_in),
    .halt_in       (halt_in),
    .burst_len_in  (burst_len_in),
    .cpu_en_out    (cpu_en_out),
    .mode_out      (mode_out),
    .busy_out      (busy_out),
    .step_cnt_out  (step_cnt_out)
  );

  step_ctrl #(.CNT_W(4)) dut4 (
    .clk_in        (clk_in),
    .RST_in        (RST_in),
    .step_pulse_in (step_pulse_in),
    .mode_pulse_in (mode_pulse_in),
    .halt_in       (halt_in),
    .burst_len_in  (burst_len_in),
    .cpu_en_out    (cpu_en4),
    .mode_out      (mode4),
    .busy_out      (busy4),
    .step_cnt_out  (step_cnt4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check_val("cpu_en",  {31'd0, cpu_en_out}, {31'd0, m_en});
    check_val("mode",    {30'd0, mode_out}, m_mode);
    check_val("busy",    {31'd0, busy_out}, (m_halted || m_left != 0) ? 32'd1 : 32'd0);
    check_val("cnt16",   {16'd0, step_cnt_out}, m_cnt % 65536);
    check_val("cnt4",    {28'd0, step_cnt4}, m_cnt % 16);
    check_val("en4",     {31'd0, cpu_en4}, {31'd0, m_en});
    check_val("busy4",   {31'd0, busy4}, {31'd0, busy_out});
    check_val("mode4",   {30'd0, mode4}, m_mode);
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_cnt = 0; m_halted = 1'b0; m_en = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge(input bit s, input bit mp, input bit h,
                            input logic [3:0] len);
    if (m_en) m_cnt = (m_cnt + 1) % 65536;
    if (m_halted) begin
      if (s && !h) m_halted = 1'b0;
    end else if (m_left != 0) begin
      if (h) begin
        m_halted = 1'b1;
        m_left   = 0;
      end else if (m_left < 0) begin
        if (s) m_left = 0;
      end else begin
        m_left = m_left - 1;
      end
    end else begin
      if (mp) m_mode = (m_mode + 1) % 3;
      else if (s) begin
        if (m_mode == 0)      m_left = 1;
        else if (m_mode == 1) m_left = (len == 4'd0) ? 16 : int'(len);
        else                  m_left = -1;
      end
    end
    m_en = !m_halted && (m_left != 0);
  endtask

  task automatic cyc(input bit s, input bit mp, input bit h, input logic [3:0] len);
    step_pulse_in = s;
    mode_pulse_in = mp;
    halt_in       = h;
    burst_len_in  = len;
    @(posedge clk_in);
    model_edge(s, mp, h, len);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, h, 4'($urandom_range(0, 15)));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk_in);
    step_pulse_in = 1'b0; mode_pulse_in = 1'b0; halt_in = 1'b0;
    #2;
    RST_in = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk_in);
    RST_in = 1'b0;
  endtask

  initial begin
    int ens;
    int wrap_exp;
    bit hv;
    RST_in = 1'b1;
    step_pulse_in = 1'b0; mode_pulse_in = 1'b0; halt_in = 1'b0;
    burst_len_in = 4'd0;
    model_reset();
    #1;
    check_all();
    @(negedge clk_in);
    RST_in = 1'b0;

    // Single step right after release.
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    idle(3, 1'b0);
    check_val("single_cnt", {16'd0, step_cnt_out}, 32'd1);

    // Burst of 5 with an ignored step pulse and length change mid-burst.
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd5);
    idle(2, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd9);
    idle(6, 1'b0);
    check_val("burst5_cnt", {16'd0, step_cnt_out}, 32'd6);

    // Burst with length 0 runs 16 cycles.
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    idle(18, 1'b0);
    check_val("burst16_cnt", {16'd0, step_cnt_out}, 32'd22);

    // Run for 100 cycles then pause.
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    idle(100, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    idle(3, 1'b0);
    ens = int'(step_cnt_out) - 22;
    check_val("run_ens", ens, 32'd101);

    // Halt during run, ignored step while halt high, release.
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    idle(5, 1'b0);
    idle(3, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    idle(2, 1'b0);

    // Mode pulse during run is ignored.
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    idle(2, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    idle(2, 1'b0);

    // Back to mode 0, then simultaneous pulses: mode wins, no enable.
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0);
    idle(2, 1'b0);
    check_val("simul_mode", {30'd0, mode_out}, 32'd1);

    // Step request with halt already high: one enable, then halted.
    cyc(1'b1, 1'b0, 1'b1, 4'd4);
    idle(3, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);

    // Reset in the middle of a 10-cycle burst.
    cyc(1'b1, 1'b0, 1'b0, 4'd10);
    idle(3, 1'b0);
    do_reset();
    idle(12, 1'b0);

    // Counter wrap on the 4-bit instance: 17 single steps.
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      cyc(1'b0, 1'b0, 1'b0, 4'd0);
    end
    wrap_exp = 17 % 16;
    check_val("wrap4", {28'd0, step_cnt4}, wrap_exp);

    // Randomized traffic.
    hv = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) hv = ~hv;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, hv,
            4'($urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
